// File: rtl/multi_tone_generator_if.sv
// Host write port and wave outputs of the multi-tone generator.
interface multi_tone_generator_if #(
  parameter int NCH = 3
);
  logic [3:0]       d_i;
  logic             a0_i;
  logic             wr_i;
  logic [NCH-1:0]   sout_o;
  logic [4*NCH-1:0] level_o;

  modport master (output d_i, a0_i, wr_i, input sout_o, level_o);
  modport slave  (input d_i, a0_i, wr_i, output sout_o, level_o);
endinterface

// File: rtl/multi_tone_generator.sv
// NCH-channel square/triangle/noise tone generator programmed through a nibble-wide host port.
module multi_tone_generator #(
  parameter int NCH   = 3,
  parameter int DIVW  = 12,
  parameter int PRESC = 4
) (
  input logic                   clk,
  input logic                   rst,
  multi_tone_generator_if.slave host
);
  localparam int         NNIB      = DIVW / 4;
  localparam logic [3:0] LAST_NIB  = 4'(NNIB - 1);
  localparam logic [3:0] NCH_L     = 4'(NCH);
  localparam logic [3:0] ADDR_VOL  = 4'h4;
  localparam logic [3:0] ADDR_MODE = 4'h5;
  localparam logic [3:0] ADDR_CTRL = 4'h6;
  localparam logic [3:0] ADDR_CSEL = 4'hF;

  typedef enum logic [1:0] {
    MODE_SQUARE     = 2'd0,
    MODE_TRIANGLE   = 2'd1,
    MODE_NOISE      = 2'd2,
    MODE_SQUARE_ALT = 2'd3
  } mode_e;

  logic [PRESC-1:0] presc_q, presc_d;
  logic [3:0]       addr_q, addr_d, csel_q, csel_d;
  logic [DIVW-1:0]  period_q [NCH], period_d [NCH];
  logic [DIVW-1:0]  shadow_q [NCH], shadow_d [NCH];
  logic [DIVW-1:0]  count_q  [NCH], count_d  [NCH];
  logic [3:0]       volume_q [NCH], volume_d [NCH];
  mode_e            mode_q [NCH], mode_d [NCH];
  mode_e            waveMode_q [NCH], waveMode_d [NCH];
  logic [4:0]       step_q [NCH], step_d [NCH];
  logic [14:0]      lfsr_q [NCH], lfsr_d [NCH];
  logic [3:0]       level_q [NCH], level_d [NCH];
  logic [NCH-1:0]   enable_q, enable_d, pending_q, pending_d;
  logic [NCH-1:0]   square_q, square_d, changed_q, changed_d;
  logic [NCH-1:0]   soutW, run, expire, phaseRst;
  logic [3:0]       wave4 [NCH];
  logic             tick, chanWrite;

  // Output bit and 4-bit wave follow the mode latched at the last expiry, not the programmed one.
  always_comb begin
    soutW = '0;
    for (int c = 0; c < NCH; c++) begin
      wave4[c] = '0;
      case (waveMode_q[c])
        MODE_TRIANGLE: begin
          soutW[c] = step_q[c][4];
          wave4[c] = step_q[c][4] ? ~step_q[c][3:0] : step_q[c][3:0];
        end
        MODE_NOISE: begin
          soutW[c] = lfsr_q[c][0];
          wave4[c] = {4{lfsr_q[c][0]}};
        end
        default: begin
          soutW[c] = square_q[c];
          wave4[c] = {4{square_q[c]}};
        end
      endcase
    end
  end

  always_comb begin
    presc_d    = presc_q + PRESC'(1);
    addr_d     = addr_q;
    csel_d     = csel_q;
    period_d   = period_q;
    shadow_d   = shadow_q;
    count_d    = count_q;
    volume_d   = volume_q;
    mode_d     = mode_q;
    waveMode_d = waveMode_q;
    step_d     = step_q;
    lfsr_d     = lfsr_q;
    level_d    = level_q;
    enable_d   = enable_q;
    pending_d  = pending_q;
    square_d   = square_q;
    changed_d  = '0;
    run        = '0;
    expire     = '0;
    phaseRst   = '0;
    tick       = &presc_q;
    chanWrite  = host.wr_i && !host.a0_i && (csel_q < NCH_L);

    if (host.wr_i) begin
      if (host.a0_i) begin
        addr_d = host.d_i;
      end else begin
        if (addr_q == ADDR_CSEL) csel_d = host.d_i;
        if (addr_q < LAST_NIB) addr_d = addr_q + 4'd1;
      end
    end

    for (int c = 0; c < NCH; c++) begin
      run[c]       = enable_q[c] && (period_q[c] != '0);
      expire[c]    = run[c] && tick && (count_q[c] + DIVW'(1) == period_q[c]);
      phaseRst[c]  = chanWrite && (csel_q == 4'(c)) && (addr_q == ADDR_CTRL) && host.d_i[1];
      changed_d[c] = expire[c] || phaseRst[c];

      // LEVEL trails the wave state by one cycle and freezes with a stopped channel.
      if (run[c] || changed_q[c])
        level_d[c] = 4'((8'(wave4[c]) * (8'(volume_q[c]) + 8'd1)) >> 4);

      if (run[c] && tick) count_d[c] = expire[c] ? '0 : count_q[c] + DIVW'(1);

      if (expire[c]) begin
        waveMode_d[c] = mode_q[c];
        case (mode_q[c])
          MODE_TRIANGLE: step_d[c] = step_q[c] + 5'd1;
          MODE_NOISE:    lfsr_d[c] = {lfsr_q[c][13:0], lfsr_q[c][14] ^ lfsr_q[c][13]};
          default:       square_d[c] = ~square_q[c];
        endcase
      end

      // The expiry above compared against the old period; the committed one counts from here.
      if (pending_q[c] && (expire[c] || !run[c])) begin
        period_d[c]  = shadow_q[c];
        pending_d[c] = 1'b0;
      end

      if (chanWrite && (csel_q == 4'(c))) begin
        if (addr_q <= LAST_NIB) begin
          shadow_d[c][{addr_q, 2'b00} +: 4] = host.d_i;
          if (addr_q == LAST_NIB) pending_d[c] = 1'b1;
        end else if (addr_q == ADDR_VOL) begin
          volume_d[c] = host.d_i;
        end else if (addr_q == ADDR_MODE) begin
          mode_d[c] = mode_e'(host.d_i[1:0]);
        end else if (addr_q == ADDR_CTRL) begin
          enable_d[c] = host.d_i[0];
        end
      end

      if (phaseRst[c]) begin
        count_d[c]  = '0;
        square_d[c] = 1'b0;
        step_d[c]   = '0;
        lfsr_d[c]   = 15'h0001;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      addr_q    <= '0;
      csel_q    <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      square_q  <= '0;
      changed_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        period_q[c]   <= '0;
        shadow_q[c]   <= '0;
        count_q[c]    <= '0;
        volume_q[c]   <= '0;
        mode_q[c]     <= MODE_SQUARE;
        waveMode_q[c] <= MODE_SQUARE;
        step_q[c]     <= '0;
        lfsr_q[c]     <= 15'h0001;
        level_q[c]    <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      addr_q     <= addr_d;
      csel_q     <= csel_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      square_q   <= square_d;
      changed_q  <= changed_d;
      period_q   <= period_d;
      shadow_q   <= shadow_d;
      count_q    <= count_d;
      volume_q   <= volume_d;
      mode_q     <= mode_d;
      waveMode_q <= waveMode_d;
      step_q     <= step_d;
      lfsr_q     <= lfsr_d;
      level_q    <= level_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign host.sout_o[c]          = soutW[c];
    assign host.level_o[4*c +: 4]  = level_q[c];
  end
endmodule
